clkce_mux: RTL



---
 rtl/clkce_mux_if.sv | 31 +++
 rtl/clkce_mux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/clkce_mux_if.sv
// clkce_mux_if
//   Request/ack and divided-clock output bundle for clkce_mux.
//   master : rate requester (drives sel_in/sel_req, observes the rest)
//   slave  : clkce_mux itself
//   sel_in/sel_req   : requested channel and its strobe
//   sel_ack/sel_err  : one-cycle result pulses
//   busy/active      : switch-in-progress flag, one-hot running channel
//   out_clk/out_ce   : registered clock level and period-end enable
interface clkce_mux_if #(
  parameter int NCH   = 3,
  parameter int SEL_W = 2
);
  logic [SEL_W-1:0] sel_in;
  logic             sel_req;
  logic             sel_ack;
  logic             sel_err;
  logic             busy;
  logic [NCH-1:0]   active;
  logic             out_clk;
  logic             out_ce;

  modport master (
    output sel_in, sel_req,
    input  sel_ack, sel_err, busy, active, out_clk, out_ce
  );

  modport slave (
    input  sel_in, sel_req,
    output sel_ack, sel_err, busy, active, out_clk, out_ce
  );
endinterface

// File: rtl/clkce_mux.sv
// clkce_mux
//   Glitch-free rate selector in a single master clock domain. One of NCH
//   divided rates is emitted as a registered clock level (out_clk) and a
//   one-cycle enable in the last cycle of each period (out_ce). A switch
//   lets the old channel finish its period (DRAIN), inserts GAP_CYC dead
//   cycles (GAP), then starts the new channel at phase 0 with sel_ack.
//
//   Ports: clk, rst (synchronous, active-high), bus (clkce_mux_if.slave).
//
//   Optional: define SEL_SYNC_EN to treat sel_req as asynchronous; it is
//   then synchronised (2 flops), rising-edge detected and registered,
//   giving 3 cycles of extra latency and one request per held level.
module clkce_mux #(
  parameter int                    NCH       = 3,
  parameter int                    SEL_W     = 2,
  parameter int                    CNT_W     = 8,
  parameter logic [NCH*CNT_W-1:0]  DIVS      = {8'd4, 8'd2, 8'd1},
  parameter int                    GAP_CYC   = 2,
  parameter int                    RESET_SEL = 0
) (
  input  logic       clk,
  input  logic       rst,
  clkce_mux_if.slave bus
);

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_GAP} state_e;

  localparam int                GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CNT_W-1:0]  RST_DIV = DIVS[RESET_SEL*CNT_W +: CNT_W];

  function automatic logic [CNT_W-1:0] div_of(input logic [SEL_W-1:0] ch);
    return DIVS[ch*CNT_W +: CNT_W];
  endfunction

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   cur_q, cur_d;
  logic [SEL_W-1:0]   nxt_q, nxt_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [NCH-1:0]     active_q, active_d;
  logic               out_clk_q, out_clk_d;
  logic               out_ce_q, out_ce_d;

  logic               req;
  logic [SEL_W-1:0]   sel;

  // ---------------------------------------------------------------- request
`ifdef SEL_SYNC_EN
  logic [2:0]         sync_q, sync_d;
  logic               req_q, req_d;
  logic [SEL_W-1:0]   sel_q, sel_d;

  always_comb begin
    sync_d = {sync_q[1:0], bus.sel_req};
    req_d  = sync_q[1] & ~sync_q[2];
    // sel_in is taken on the detected edge and presented with the request
    sel_d  = req_d ? bus.sel_in : sel_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      req_q  <= 1'b0;
      sel_q  <= '0;
    end else begin
      sync_q <= sync_d;
      req_q  <= req_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    req = req_q;
    sel = sel_q;
  end
`else
  always_comb begin
    req = bus.sel_req;
    sel = bus.sel_in;
  end
`endif

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_RUN;
      cur_q     <= SEL_W'(RESET_SEL);
      nxt_q     <= SEL_W'(RESET_SEL);
      cnt_q     <= '0;
      gap_q     <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      active_q  <= NCH'(1) << RESET_SEL;
      out_clk_q <= 1'b1;
      out_ce_q  <= (RST_DIV == CNT_W'(1));
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      active_q  <= active_d;
      out_clk_q <= out_clk_d;
      out_ce_q  <= out_ce_d;
    end
  end

  // -------------------------------------------------------------- next state
  logic [CNT_W-1:0] d_cur;
  logic             last;
  logic [CNT_W-1:0] cnt_step;

  always_comb begin
    d_cur    = div_of(cur_q);
    last     = (cnt_q == d_cur - 1'b1);
    cnt_step = last ? '0 : cnt_q + 1'b1;

    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_RUN: begin
        cnt_d = cnt_step;
        if (req) begin
          if (32'(sel) >= NCH) begin
            err_d = 1'b1;
          end else if (sel == cur_q) begin
            ack_d = 1'b1;
          end else begin
            nxt_d   = sel;
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // the last old-channel cycle still runs normally, out_ce included
        if (last) begin
          if (GAP_CYC == 0) begin
            state_d = S_RUN;
            cur_d   = nxt_q;
            cnt_d   = '0;
            ack_d   = 1'b1;
          end else begin
            state_d = S_GAP;
            gap_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_step;
        end
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_d = S_RUN;
          cur_d   = nxt_q;
          cnt_d   = '0;
          ack_d   = 1'b1;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // ------------------------------------------------------------------ output
  // Outputs are registered from the next-state values so each flop shows
  // the waveform of the cycle it belongs to.
  logic [CNT_W-1:0] d_nxt;
  logic [CNT_W:0]   half;

  always_comb begin
    d_nxt     = div_of(cur_d);
    half      = ({1'b0, d_nxt} + (CNT_W+1)'(1)) >> 1;
    out_clk_d = (state_d != S_GAP) && ({1'b0, cnt_d} < half);
    out_ce_d  = (state_d != S_GAP) && (cnt_d == d_nxt - 1'b1);
    busy_d    = (state_d != S_RUN);
    active_d  = '0;
    for (int i = 0; i < NCH; i++) active_d[i] = (cur_d == SEL_W'(i));
  end

  assign bus.sel_ack = ack_q;
  assign bus.sel_err = err_q;
  assign bus.busy    = busy_q;
  assign bus.active  = active_q;
  assign bus.out_clk = out_clk_q;
  assign bus.out_ce  = out_ce_q;

endmodule
